// File: rtl/iterative_alu_pkg.sv
// Shared function codes and FSM state type for iterative_alu.
// Optional multiply support is controlled by ITERATIVE_ALU_MUL_EN.
package iterative_alu_pkg;

    localparam logic [4:0] ALU_F_A   = 5'd0;
    localparam logic [4:0] ALU_F_B   = 5'd1;
    localparam logic [4:0] ALU_F_SUB = 5'd2;
    localparam logic [4:0] ALU_F_ADD = 5'd3;
    localparam logic [4:0] ALU_F_NOT = 5'd4;
    localparam logic [4:0] ALU_F_XOR = 5'd5;
    localparam logic [4:0] ALU_F_AND = 5'd6;
    localparam logic [4:0] ALU_F_OR  = 5'd7;
    localparam logic [4:0] ALU_F_SHL = 5'd8;
    localparam logic [4:0] ALU_F_SHR = 5'd9;
    localparam logic [4:0] ALU_F_MUL = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
`ifdef ITERATIVE_ALU_MUL_EN
        , ST_MUL
`endif
    } alu_state_t;

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
// The tri-stated result y is a separate top-level port of iterative_alu.
interface iterative_alu_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
);
    logic               start;
    logic [4:0]         f;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               csel;
    logic               ucin;
    logic               fcin;
    logic               notOE;
    logic               cout;
    logic               zout;
    logic               busy;
    logic               done;
    logic               illegal;

    modport master (
        output start, f, a, b, shamt, csel, ucin, fcin, notOE,
        input  cout, zout, busy, done, illegal
    );

    modport slave (
        input  start, f, a, b, shamt, csel, ucin, fcin, notOE,
        output cout, zout, busy, done, illegal
    );
endinterface

// File: rtl/iterative_alu_core.sv
// alu_core_comb: combinational result/carry for codes 0-7 plus illegal-code detection.
// With ITERATIVE_ALU_MUL_EN defined, code 10 is treated as legal.
module alu_core_comb
    import iterative_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       i_f,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout,
    output logic             o_illegal
);

    logic [WIDTH:0] w_cin_ext;
    assign w_cin_ext = {{WIDTH{1'b0}}, i_cin};

    always_comb begin
        o_y       = '0;
        o_cout    = 1'b0;
        o_illegal = 1'b0;
        case (i_f)
            ALU_F_A:   {o_cout, o_y} = {1'b0, i_a} + w_cin_ext;
            ALU_F_B:   o_y = i_b;
            ALU_F_SUB: {o_cout, o_y} = {1'b0, i_a} + {1'b0, ~i_b} + w_cin_ext;
            ALU_F_ADD: {o_cout, o_y} = {1'b0, i_a} + {1'b0, i_b} + w_cin_ext;
            ALU_F_NOT: o_y = ~i_a;
            ALU_F_XOR: o_y = i_a ^ i_b;
            ALU_F_AND: o_y = i_a & i_b;
            ALU_F_OR:  o_y = i_a | i_b;
            // Iterative codes are sequenced by the top level; only legality matters here.
            ALU_F_SHL, ALU_F_SHR: o_illegal = 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
            ALU_F_MUL: o_illegal = 1'b0;
`endif
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/iterative_alu.sv
// Clocked ALU: single-cycle ops, bit-serial shifts, tri-stated result bus.
// Define ITERATIVE_ALU_MUL_EN to add the WIDTH-cycle shift-add multiply (f = 10).
module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clock,
    input  logic             notReset,
    iterative_alu_if.slave   bus,
    output logic [WIDTH-1:0] y
);

    localparam int CNT_W = SHAMT_W + 1;

    alu_state_t         r_state;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir_left;
    logic               r_cout;
    logic               r_zout;
    logic               r_busy;
    logic               r_done;
    logic               r_illegal;

    logic               w_cin;
    logic [WIDTH-1:0]   w_core_y;
    logic               w_core_cout;
    logic               w_core_ill;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_shift_out;

`ifdef ITERATIVE_ALU_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] w_acc_next;

    // r_work holds the multiplier, consumed LSB first.
    assign w_acc_next = r_acc + (r_work[0] ? r_mcand : '0);
`endif

    assign w_cin = bus.csel ? bus.fcin : bus.ucin;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .i_f       (bus.f),
        .i_a       (bus.a),
        .i_b       (bus.b),
        .i_cin     (w_cin),
        .o_y       (w_core_y),
        .o_cout    (w_core_cout),
        .o_illegal (w_core_ill)
    );

    always_comb begin
        w_shift_next = '0;
        w_shift_out  = 1'b0;
        if (r_dir_left) begin
            w_shift_next = {r_work[WIDTH-2:0], 1'b0};
            w_shift_out  = r_work[WIDTH-1];
        end else begin
            w_shift_next = {1'b0, r_work[WIDTH-1:1]};
            w_shift_out  = r_work[0];
        end
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_cout     <= 1'b0;
            r_zout     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
            r_acc      <= '0;
            r_mcand    <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.f == ALU_F_SHL || bus.f == ALU_F_SHR) begin
                            if (bus.shamt == '0) begin
                                r_result <= bus.a;
                                r_cout   <= 1'b0;
                                r_zout   <= (bus.a == '0);
                                r_done   <= 1'b1;
                            end else begin
                                r_work     <= bus.a;
                                r_dir_left <= (bus.f == ALU_F_SHL);
                                r_cnt      <= {1'b0, bus.shamt};
                                r_busy     <= 1'b1;
                                r_state    <= ST_SHIFT;
                            end
                        end
`ifdef ITERATIVE_ALU_MUL_EN
                        else if (bus.f == ALU_F_MUL) begin
                            r_work  <= bus.b;
                            r_acc   <= '0;
                            r_mcand <= {{WIDTH{1'b0}}, bus.a};
                            r_cnt   <= CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
                        end
`endif
                        else begin
                            r_result  <= w_core_y;
                            r_cout    <= w_core_cout;
                            r_zout    <= (w_core_y == '0);
                            r_illegal <= w_core_ill;
                            r_done    <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    r_work <= w_shift_next;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    // Flags commit only on the final step so intermediates stay hidden.
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_shift_next;
                        r_cout   <= w_shift_out;
                        r_zout   <= (w_shift_next == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end

`ifdef ITERATIVE_ALU_MUL_EN
                ST_MUL: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << 1;
                    r_work  <= r_work >> 1;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_cout   <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zout   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign y           = bus.notOE ? {WIDTH{1'bz}} : r_result;
    assign bus.cout    = r_cout;
    assign bus.zout    = r_zout;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;

endmodule

// File: tb/tb_iterative_alu.sv
// Randomised and directed bench for iterative_alu against an arithmetic reference model.
// Compile with ITERATIVE_ALU_MUL_EN to cover the multiply path.
module tb_iterative_alu;

    localparam int W  = 16;
    localparam int SW = 4;

    logic         clock    = 1'b0;
    logic         notReset = 1'b0;
    wire  [W-1:0] y;

    iterative_alu_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

    iterative_alu #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock    (clock),
        .notReset (notReset),
        .bus      (bus),
        .y        (y)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result from the function-code rules using plain integer arithmetic.
    task automatic ref_model(input int f, input longint unsigned a, input longint unsigned b,
                             input int k, input int cin,
                             output longint unsigned ey, output int ec, output int eill,
                             output int elat);
        longint unsigned mask;
        longint unsigned s;
        mask = (64'd1 << W) - 1;
        ey = 0; ec = 0; eill = 0; elat = 0; s = 0;
        case (f)
            0: begin s = a + cin;                    ey = s & mask; ec = int'((s >> W) & 1); end
            1: ey = b;
            2: begin s = a + ((~b) & mask) + cin;    ey = s & mask; ec = int'((s >> W) & 1); end
            3: begin s = a + b + cin;                ey = s & mask; ec = int'((s >> W) & 1); end
            4: ey = (~a) & mask;
            5: ey = a ^ b;
            6: ey = a & b;
            7: ey = a | b;
            8: begin
                ey = (a << k) & mask;
                ec = (k > 0) ? int'((a >> (W - k)) & 1) : 0;
                elat = k;
            end
            9: begin
                ey = a >> k;
                ec = (k > 0) ? int'((a >> (k - 1)) & 1) : 0;
                elat = k;
            end
`ifdef ITERATIVE_ALU_MUL_EN
            10: begin
                s = a * b;
                ey = s & mask;
                ec = ((s >> W) != 0) ? 1 : 0;
                elat = W;
            end
`endif
            default: eill = 1;
        endcase
    endtask

    task automatic run_op(input int f, input int a, input int b, input int k,
                          input bit csel, input bit ucin, input bit fcin, input bit inject);
        longint unsigned ey;
        int ec, eill, elat, i;
        ref_model(f, longint'(a), longint'(b), k, csel ? int'(fcin) : int'(ucin), ey, ec, eill, elat);
        @(negedge clock);
        bus.f = 5'(f); bus.a = 16'(a); bus.b = 16'(b); bus.shamt = 4'(k);
        bus.csel = csel; bus.ucin = ucin; bus.fcin = fcin;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        i = 0;
        if (elat > 0) check_eq("busy_on", 32'(bus.busy), 32'd1);
        while (!bus.done && i < 200) begin
            if (inject && i == 0) begin
                bus.f = 5'd3; bus.a = 16'h1111; bus.b = 16'h2222;
                bus.start = 1'b1;
            end
            @(negedge clock);
            bus.start = 1'b0;
            i++;
        end
        check_eq("latency", 32'(i), 32'(elat));
        check_eq("y", 32'(y), 32'(ey));
        check_eq("cout", 32'(bus.cout), 32'(ec));
        check_eq("zout", 32'(bus.zout), (ey == 0) ? 32'd1 : 32'd0);
        check_eq("illegal", 32'(bus.illegal), 32'(eill));
        @(negedge clock);
        check_eq("done_pulse", 32'(bus.done), 32'd0);
        check_eq("y_hold", 32'(y), 32'(ey));
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0; bus.f = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
        bus.csel = 1'b0; bus.ucin = 1'b0; bus.fcin = 1'b0; bus.notOE = 1'b0;

        repeat (2) @(negedge clock);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_zout", 32'(bus.zout), 32'd1);
        check_eq("rst_cout", 32'(bus.cout), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
        notReset = 1'b1;

        // Reset while a shift is in flight.
        @(negedge clock);
        bus.f = 5'd8; bus.a = 16'h0001; bus.shamt = 4'd8; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("mid_busy", 32'(bus.busy), 32'd1);
        notReset = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_y", 32'(y), 32'd0);
        check_eq("mid_rst_zout", 32'(bus.zout), 32'd1);
        @(negedge clock);
        notReset = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.done) done_seen++;
        end
        check_eq("mid_no_done", 32'(done_seen), 32'd0);

        // Directed cases.
        run_op(3, 'hFFFF, 'h0001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(2, 'h0005, 'h0005, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(2, 'h0004, 'h0005, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op(9, 'h8003, 'h0000, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(8, 'h8001, 'h0000, 15, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(8, 'hABCD, 'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(9, 'h0000, 'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(31, 'h1234, 'h5678, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(10, 'h0100, 'h0100, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(0, 'hFFFF, 'h0000, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back: second start issued in the first op's done cycle.
        @(negedge clock);
        bus.f = 5'd5; bus.a = 16'hAAAA; bus.b = 16'hFFFF; bus.start = 1'b1;
        @(negedge clock);
        check_eq("b2b_done1", 32'(bus.done), 32'd1);
        check_eq("b2b_y1", 32'(y), 32'h5555);
        bus.f = 5'd7; bus.a = 16'h1234; bus.b = 16'h00F0; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check_eq("b2b_done2", 32'(bus.done), 32'd1);
        check_eq("b2b_y2", 32'(y), 32'h12F4);
        bus.notOE = 1'b1;
        #1;
        check_eq("oe_off", (y === 16'h12F4) ? 32'd1 : 32'd0, 32'd0);
        bus.notOE = 1'b0;
        #1;
        check_eq("oe_on", 32'(y), 32'h12F4);

        // Randomised operations.
        for (int n = 0; n < 60; n++) begin
            int rf;
            rf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 31)) : int'($urandom_range(0, 10));
            run_op(rf, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 16'hFFFF)),
                   int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Accepts one operation per start/done handshake and registers result, carry and zero.
- Adds multi-bit shifts executed one bit per cycle.
- Drives a tri-stateable result onto the shared data bus; sits between the register file read ports and the bus, sequenced by the control unit.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- SHAMT_W, 4, width of shift-amount input; must equal clog2(WIDTH).

Ports:
- clock  in  1  system clock, all state on rising edge.
- notReset  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- f  in  5  function code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- shamt  in  SHAMT_W  shift amount, sampled with start.
- csel  in  1  carry-in select: 1 = fcin, 0 = ucin.
- ucin  in  1  microcode carry-in.
- fcin  in  1  flag carry-in.
- notOE  in  1  output enable, active-low.
- y  out  WIDTH  registered result; high-Z when notOE = 1.
- cout  out  1  registered carry flag.
- zout  out  1  registered zero flag, equals (result == 0).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result and flags are valid.
- illegal  out  1  pulses with done when f was unknown.

Behaviour:
- Reset (async, notReset = 0): state = IDLE, result = 0, cout = 0, zout = 1, busy = 0, done = 0, illegal = 0. Any in-flight operation is abandoned with no done pulse. y follows notOE even during reset.
- Carry in: cin = csel ? fcin : ucin, latched at the start edge.
- States: IDLE, SHIFT, MUL (MUL exists only with the optional feature).
- IDLE with start = 1:
  - Single-cycle ops: result and flags written at the start edge; busy stays 0; done = 1 for the following cycle.
  - SHL/SHR with shamt = 0: same as single-cycle; result = a, cout = 0.
  - SHL/SHR with shamt = k > 0: load a into the working register, counter = k, go to SHIFT; busy = 1.
- SHIFT: shift one bit per clock.
  - cout takes the bit shifted out; vacated bit is 0.
  - Counter decrements each clock; on counter reaching 0, return to IDLE and pulse done.
  - done is high in the cycle after edge k, counting the start edge as edge 0.
- start while busy = 1 is ignored and not queued. start in the done cycle is accepted (back-to-back).
- Function codes and results (WIDTH-bit, modulo 2^WIDTH):
  - 0 A: y = a + cin; cout = carry out.
  - 1 B: y = b; cout = 0.
  - 2 SUB: y = a + ~b + cin (a - b - 1 + cin); cout = carry out (1 = no borrow).
  - 3 ADD: y = a + b + cin; cout = carry out.
  - 4 NOT: y = ~a.
  - 5 XOR: y = a ^ b.
  - 6 AND: y = a & b.
  - 7 OR: y = a | b.
  - 8 SHL.
  - 9 SHR.
  - 10 MUL (optional feature only).
  - Logic ops 4-7 set cout = 0.
- Any other f: result = 0, cout = 0, illegal = 1 with done (single-cycle).
- zout is updated together with the result and only at completion; intermediate shift values are not visible on zout.
- Outputs hold their last completed value until the next completion.

Optional Feature:
- Macro ITERATIVE_ALU_MUL_EN.
- Defined: f = 10 performs an unsigned shift-add multiply, low WIDTH bits into y; cout = 1 if any high-half bit is nonzero. Takes exactly WIDTH cycles in state MUL: done in the cycle after edge WIDTH; busy = 1 throughout.
- Undefined: f = 10 is illegal; the MUL state and its datapath are absent.

Decomposition:
- Shared include alu_common: ALU_F_* function-code constants (5-bit, including ALU_F_SHL, ALU_F_SHR, ALU_F_MUL) and state encodings.
- One sub-module alu_core_comb: combinational WIDTH-parameterised arithmetic/logic unit producing result and carry for codes 0-7 plus illegal detection.
- Top level holds the FSM, counter, working register, flags and tri-state.

Test Plan:
- Reset mid-shift: start SHL a = 16'h0001, shamt = 8; assert notReset low after 3 cycles -> no done, busy = 0, y = 0, zout = 1 once notOE = 0.
- ADD: a = 16'hFFFF, b = 16'h0001, ucin = 0, csel = 0 -> done 1 cycle later, y = 0, cout = 1, zout = 1.
- SUB: a = 16'h0005, b = 16'h0005, fcin = 1, csel = 1 -> y = 0, cout = 1. Repeat with a = 4 -> y = 16'hFFFF, cout = 0.
- SHR: a = 16'h8003, shamt = 2 -> busy for 2 cycles, done in the cycle after edge 2, y = 16'h2000, cout = 1. Issue start during busy -> ignored.
- Back-to-back and tri-state: XOR a = 16'hAAAA, b = 16'hFFFF, then start OR in the done cycle -> two done pulses on consecutive cycles. notOE = 1 -> y = Z.
- Illegal code: f = 5'h1F -> illegal = 1 with done, y = 0. Without ITERATIVE_ALU_MUL_EN, f = 10 is also illegal. With it, 16'h0100 × 16'h0100 -> 16 cycles, y = 0, cout = 1.
